// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Contents:
//   state_t     - responder FSM states (IDLE, WAIT, RESP)
//   ADDR_W      - byte address width
//   DATA_W      - data word width
//   MASK_W      - byte-enable width
//   mergeBytes  - replaces the bytes of a word selected by a byte mask
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bit i of mask selects byte i (bits [8i+7:8i]) from newWord; other bytes keep oldWord.
  function automatic logic [DATA_W-1:0] mergeBytes(
    input logic [DATA_W-1:0] oldWord,
    input logic [DATA_W-1:0] newWord,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with byte write enables and a registered read.
// Ports:
//   clk_i    - clock
//   en_i     - access enable for this cycle
//   we_i     - 1 = byte-masked write, 0 = read
//   idx_i    - word index
//   wdata_i  - write data
//   wmask_i  - byte enables for a write
//   rdata_o  - read data, registered; holds its value until the next read
// The array and the read register are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // A write does not disturb the read register, so the last load result stays put.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= mergeBytes(mem_q[idx_i], wdata_i, wmask_i);
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the core's load/store interface.
// Accepts one request at a time, performs the read or byte-masked write after
// LATENCY cycles, then presents the response until the consumer takes it.
// Ports:
//   clk_i, rst_ni               - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   - request handshake
//   req_we_i                    - 1 = store, 0 = load
//   req_addr_i                  - byte address
//   req_wdata_i, req_wmask_i    - store data and byte enables
//   rsp_valid_o / rsp_ready_i   - response handshake
//   rsp_rdata_o                 - load data; 0 for stores and errors
//   rsp_err_o                   - misaligned or out-of-range access
// BASE_ADDR is assumed word-aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                DEPTH     = 1024,
  parameter int                LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [MASK_W-1:0] req_wmask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int           IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]   CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [ADDR_W:0] WINDOW = (ADDR_W + 1)'(4 * DEPTH);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic                err_q;

  logic                accept;
  logic                commit;
  logic                selWe;
  logic [ADDR_W-1:0]   selAddr;
  logic [DATA_W-1:0]   selWdata;
  logic [MASK_W-1:0]   selWmask;
  logic [ADDR_W-1:0]   offset;
  logic                accessErr;
  logic [DATA_W-1:0]   ramRdata;

  assign accept = req_valid_i && (state_q == IDLE);

  // With LATENCY=1 the commit edge is the accept edge itself, so the access
  // fields come straight from the request port; otherwise from the latches.
  assign commit   = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 4'd0));
  assign selWe    = (state_q == IDLE) ? req_we_i    : we_q;
  assign selAddr  = (state_q == IDLE) ? req_addr_i  : addr_q;
  assign selWdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
  assign selWmask = (state_q == IDLE) ? req_wmask_i : wmask_q;

  // Range check on the full 32-bit offset so addresses above the window
  // error instead of aliasing onto a low word.
  assign offset    = selAddr - BASE_ADDR;
  assign accessErr = (|offset[1:0]) || (selAddr < BASE_ADDR) || ({1'b0, offset} >= WINDOW);

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) uArray (
    .clk_i   (clk_i),
    .en_i    (commit && !accessErr),
    .we_i    (selWe),
    .idx_i   (offset[IDX_W+1:2]),
    .wdata_i (selWdata),
    .wmask_i (selWmask),
    .rdata_o (ramRdata)
  );

  // Next-state logic: count down the latency in WAIT, hold RESP until taken.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wmask_q <= req_wmask_i;
      end
      if (commit) begin
        err_q <= accessErr;
      end
    end
  end

  // Outputs are decoded from registered state only; the RAM read register
  // holds its value through RESP because it is only enabled on a commit.
  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = (state_q == RESP) && err_q;
  assign rsp_rdata_o = ((state_q == RESP) && !we_q && !err_q) ? ramRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Three instances share one clock:
// index 0 uses LATENCY=2, index 1 LATENCY=4, index 2 LATENCY=1.
module tb_dmem_responder;

  logic        clk;
  logic        rstN      [3];
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [31:0] reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic [3:0]  reqWmask  [3];
  logic        rspValid  [3];
  logic        rspReady  [3];
  logic [31:0] rspRdata  [3];
  logic        rspErr    [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        scoreboard[$];
  logic [31:0] modelMem[int];

  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_responder #(
      .BASE_ADDR (32'h8000_0000),
      .DEPTH     (1024),
      .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 4 : 1))
    ) uDut (
      .clk_i       (clk),
      .rst_ni      (rstN[g]),
      .req_valid_i (reqValid[g]),
      .req_ready_o (reqReady[g]),
      .req_we_i    (reqWe[g]),
      .req_addr_i  (reqAddr[g]),
      .req_wdata_i (reqWdata[g]),
      .req_wmask_i (reqWmask[g]),
      .rsp_valid_o (rspValid[g]),
      .rsp_ready_i (rspReady[g]),
      .rsp_rdata_o (rspRdata[g]),
      .rsp_err_o   (rspErr[g])
    );
  end

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int latOf(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic modelErr(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < 32'h8000_0000) || (addr >= 32'h8000_1000);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request, predicts its response into the scoreboard, measures
  // the accept-to-response latency, and optionally holds off rsp_ready for
  // `hold` cycles while checking the response stays put.
  task automatic applyStimulus(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask,
                               input int hold);
    rsp_t exp;
    int   lat;
    int   key;
    logic [31:0] oldWord;
    exp.err  = modelErr(addr);
    exp.data = 32'h0;
    key      = k * 4096 + int'((addr - 32'h8000_0000) >> 2);
    if (!exp.err) begin
      if (we) begin
        oldWord = modelMem.exists(key) ? modelMem[key] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (mask[b]) oldWord[8*b +: 8] = wdata[8*b +: 8];
        end
        modelMem[key] = oldWord;
      end else begin
        exp.data = modelMem[key];
      end
    end
    scoreboard.push_back(exp);

    @(negedge clk);
    checkOutput("req_ready before request", 32'(reqReady[k]), 32'd1);
    reqValid[k] = 1'b1;
    reqWe[k]    = we;
    reqAddr[k]  = addr;
    reqWdata[k] = wdata;
    reqWmask[k] = mask;
    rspReady[k] = (hold == 0);
    @(posedge clk);
    #1;
    reqValid[k] = 1'b0;
    reqAddr[k]  = 32'hFFFF_FFFF;
    reqWdata[k] = 32'h5555_5555;

    lat = 1;
    while (!rspValid[k] && lat < 32) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("response latency", 32'(lat), 32'(latOf(k)));

    exp = scoreboard.pop_front();
    checkOutput("rsp_rdata", rspRdata[k], exp.data);
    checkOutput("rsp_err", 32'(rspErr[k]), 32'(exp.err));

    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        checkOutput("held rsp_valid", 32'(rspValid[k]), 32'd1);
        checkOutput("held rsp_rdata", rspRdata[k], exp.data);
        checkOutput("held rsp_err", 32'(rspErr[k]), 32'(exp.err));
        checkOutput("held req_ready", 32'(reqReady[k]), 32'd0);
      end
      @(negedge clk);
      rspReady[k] = 1'b1;
    end

    @(posedge clk);
    #1;
    checkOutput("req_ready after handshake", 32'(reqReady[k]), 32'd1);
    checkOutput("rsp_valid after handshake", 32'(rspValid[k]), 32'd0);
  endtask

  initial begin
    int   c0;
    logic sawValid;

    for (int k = 0; k < 3; k++) begin
      rstN[k]     = 1'b0;
      reqValid[k] = 1'b0;
      reqWe[k]    = 1'b0;
      reqAddr[k]  = 32'h0;
      reqWdata[k] = 32'h0;
      reqWmask[k] = 4'h0;
      rspReady[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("reset req_ready", 32'(reqReady[k]), 32'd1);
      checkOutput("reset rsp_valid", 32'(rspValid[k]), 32'd0);
      checkOutput("reset rsp_rdata", rspRdata[k], 32'd0);
      checkOutput("reset rsp_err", 32'(rspErr[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rstN[k] = 1'b1;

    // LATENCY=2: store then load the same word.
    applyStimulus(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
    checkOutput("store/load literal", modelMem[4], 32'hDEAD_BEEF);

    // Byte-masked merge.
    applyStimulus(0, 1'b1, 32'h8000_0014, 32'h1122_3344, 4'hF, 0);
    applyStimulus(0, 1'b1, 32'h8000_0014, 32'hAABB_CCDD, 4'b0101, 0);
    applyStimulus(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 0);
    checkOutput("merge literal", modelMem[5], 32'h11BB_33DD);

    // Error cases: misaligned, above window (aliases word 0), below base.
    applyStimulus(0, 1'b0, 32'h8000_0002, 32'h0, 4'h0, 0);
    applyStimulus(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0);
    applyStimulus(0, 1'b1, 32'h8000_1000, 32'h0BAD_BAD0, 4'hF, 0);
    applyStimulus(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
    applyStimulus(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
    applyStimulus(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 0);

    // Empty mask is a no-op store.
    applyStimulus(0, 1'b1, 32'h8000_0010, 32'h0000_0000, 4'h0, 0);
    applyStimulus(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);

    // Backpressure for 5 cycles on a load.
    applyStimulus(0, 1'b0, 32'h8000_0014, 32'h0, 4'h0, 5);

    // LATENCY=4: reset pulsed while the store is waiting aborts it.
    applyStimulus(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, 0);
    @(negedge clk);
    reqValid[1] = 1'b1;
    reqWe[1]    = 1'b1;
    reqAddr[1]  = 32'h8000_0020;
    reqWdata[1] = 32'hFFFF_FFFF;
    reqWmask[1] = 4'hF;
    @(posedge clk);
    #1;
    reqValid[1] = 1'b0;
    @(negedge clk);
    rstN[1] = 1'b0;
    #1;
    checkOutput("abort rsp_valid", 32'(rspValid[1]), 32'd0);
    checkOutput("abort req_ready", 32'(reqReady[1]), 32'd1);
    checkOutput("abort rsp_err", 32'(rspErr[1]), 32'd0);
    @(negedge clk);
    rstN[1] = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (rspValid[1]) sawValid = 1'b1;
    end
    checkOutput("aborted access response", 32'(sawValid), 32'd0);
    applyStimulus(1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, 0);

    // LATENCY=1: four back-to-back loads complete in eight cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, 1'b1, 32'h8000_0040 + 32'(4 * i), 32'hA000_0000 + 32'(i * 32'h0101), 4'hF, 0);
    end
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, 1'b0, 32'h8000_0040 + 32'(4 * i), 32'h0, 4'h0, 0);
    end
    checkOutput("four loads cycle count", 32'(cyc - c0), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
